// File: rtl/conditioner_pkg.sv
// conditioner_pkg: shared state encoding and parameter defaults for output_conditioner.
package conditioner_pkg;
    localparam int DEF_COUNTERWIDTH = 3;
    localparam int DEF_WAITTIME     = 3;
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        HOLD_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        HOLD_LOW  = 2'd3
    } state_e;
endpackage

// File: rtl/output_conditioner_if.sv
// output_conditioner_if: request inputs and conditioned outputs of the conditioner.
interface output_conditioner_if;
    logic rise_req;
    logic fall_req;
    logic drive;
    logic busy;
    logic risedone;
    logic falldone;
    logic dropped;
    modport master (output rise_req, fall_req, input drive, busy, risedone, falldone, dropped);
    modport slave  (input rise_req, fall_req, output drive, busy, risedone, falldone, dropped);
endinterface

// File: rtl/dwell_counter.sv
// dwell_counter: hold counter that saturates at WAITTIME-1 and flags terminal count.
module dwell_counter #(
    parameter int COUNTERWIDTH = 3,
    parameter int WAITTIME     = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [COUNTERWIDTH-1:0] cnt_q;
    assign tc_o = cnt_q == COUNTERWIDTH'(WAITTIME - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= clr_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
    end
endmodule

// File: rtl/output_conditioner.sv
// output_conditioner: turns rise/fall request pulses into a glitch-free level with a
// minimum dwell between transitions, holding at most one pending request.
module output_conditioner
    import conditioner_pkg::*;
#(
    parameter int COUNTERWIDTH = DEF_COUNTERWIDTH,
    parameter int WAITTIME     = DEF_WAITTIME
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output_conditioner_if.slave   bus
);
    state_e state_q, state_d;
    logic   pend_v_q, pend_v_d, pend_lvl_q, pend_lvl_d;
    logic   rdone_d, fdone_d, drop_d;
    logic   drive_q, busy_q, rdone_q, fdone_q, drop_q;
    logic   tc, hold, lvl, req_v, both, pv, pl;

    assign req_v = bus.rise_req ^ bus.fall_req;
    assign both  = bus.rise_req & bus.fall_req;
    assign hold  = state_q == HOLD_HIGH || state_q == HOLD_LOW;
    assign lvl   = state_q == HOLD_HIGH || state_q == IDLE_HIGH;
    // A request in the current cycle counts as pending, so it can act at this very edge.
    assign pv    = pend_v_q | req_v;
    assign pl    = req_v ? bus.rise_req : pend_lvl_q;

    always_comb begin
        state_d    = state_q;
        pend_v_d   = pend_v_q;
        pend_lvl_d = pend_lvl_q;
        rdone_d    = 1'b0;
        fdone_d    = 1'b0;
        drop_d     = both | (hold & req_v & pend_v_q);
        if (!hold) begin
            if (req_v && bus.rise_req != lvl) begin
                state_d = lvl ? HOLD_LOW : HOLD_HIGH;
                rdone_d = !lvl;
                fdone_d = lvl;
            end
        end else if (tc) begin
            pend_v_d = 1'b0;
            if (pv && pl != lvl) begin
                state_d = lvl ? HOLD_LOW : HOLD_HIGH;
                rdone_d = !lvl;
                fdone_d = lvl;
            end else begin
                state_d = lvl ? IDLE_HIGH : IDLE_LOW;
                drop_d  = drop_d | pv;
            end
        end else begin
            pend_v_d   = pv;
            pend_lvl_d = pl;
        end
    end

    dwell_counter #(.COUNTERWIDTH(COUNTERWIDTH), .WAITTIME(WAITTIME)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (rdone_d | fdone_d),
        .en_i  (hold),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_LOW;
            pend_v_q   <= 1'b0;
            pend_lvl_q <= 1'b0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdone_q    <= 1'b0;
            fdone_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_v_q   <= pend_v_d;
            pend_lvl_q <= pend_lvl_d;
            drive_q    <= state_d == HOLD_HIGH || state_d == IDLE_HIGH;
            busy_q     <= state_d == HOLD_HIGH || state_d == HOLD_LOW;
            rdone_q    <= rdone_d;
            fdone_q    <= fdone_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.drive    = drive_q;
    assign bus.busy     = busy_q;
    assign bus.risedone = rdone_q;
    assign bus.falldone = fdone_q;
    assign bus.dropped  = drop_q;
endmodule

// File: tb/tb_output_conditioner.sv
// tb_output_conditioner: directed scenarios with per-cycle expected outputs
// {drive,busy,risedone,falldone,dropped} queued at drive time and checked after each edge.
module tb_output_conditioner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;
    exp_t exp_q[$];

    output_conditioner_if bus ();
    output_conditioner #(.COUNTERWIDTH(3), .WAITTIME(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] obs;
    assign obs = {bus.drive, bus.busy, bus.risedone, bus.falldone, bus.dropped};

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b (drive,busy,risedone,falldone,dropped)", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, obs, e.exp);
        end
    end

    task automatic step(input string tag, input logic r, input logic f, input logic [4:0] exp);
        exp_t e;
        @(negedge clk);
        bus.rise_req = r;
        bus.fall_req = f;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int budget = 10;
        @(negedge clk);
        bus.rise_req = 1'b0;
        bus.fall_req = 1'b0;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 5'b11111, 5'b00000);
            exp_q.delete();
        end
    endtask

    task automatic fall_back(input string tag);
        step({tag, "_f0"}, 1'b0, 1'b1, 5'b01010);
        step({tag, "_f1"}, 1'b0, 1'b0, 5'b01000);
        step({tag, "_f2"}, 1'b0, 1'b0, 5'b01000);
        step({tag, "_f3"}, 1'b0, 1'b0, 5'b00000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rise_req = 1'b0;
        bus.fall_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        step("rise_c2", 1'b1, 1'b0, 5'b11100);
        step("rise_c3", 1'b0, 1'b0, 5'b11000);
        step("rise_c4", 1'b0, 1'b0, 5'b11000);
        step("rise_c5", 1'b0, 1'b0, 5'b10000);
        step("rise_c6", 1'b0, 1'b0, 5'b10000);
        step("idle_hi_rise_noop", 1'b1, 1'b0, 5'b10000);
        fall_back("a");

        step("pend_c2", 1'b1, 1'b0, 5'b11100);
        step("pend_c3", 1'b0, 1'b1, 5'b11000);
        step("pend_c4", 1'b0, 1'b0, 5'b11000);
        step("pend_c5", 1'b0, 1'b0, 5'b01010);
        step("pend_c6", 1'b0, 1'b0, 5'b01000);
        step("pend_c7", 1'b0, 1'b0, 5'b01000);
        step("pend_c8", 1'b0, 1'b0, 5'b00000);

        step("ovr_c2", 1'b1, 1'b0, 5'b11100);
        step("ovr_c3", 1'b0, 1'b1, 5'b11000);
        step("ovr_c4", 1'b1, 1'b0, 5'b11001);
        step("ovr_c5", 1'b0, 1'b0, 5'b10001);
        step("ovr_c6", 1'b0, 1'b0, 5'b10000);
        fall_back("b");

        step("both_idle", 1'b1, 1'b1, 5'b00001);
        step("both_idle_after", 1'b0, 1'b0, 5'b00000);
        step("fall_idle_low", 1'b0, 1'b1, 5'b00000);
        step("fall_idle_low_after", 1'b0, 1'b0, 5'b00000);

        step("tc_c2", 1'b1, 1'b0, 5'b11100);
        step("tc_c3", 1'b0, 1'b0, 5'b11000);
        step("tc_c4", 1'b0, 1'b0, 5'b11000);
        step("tc_c5", 1'b0, 1'b1, 5'b01010);
        step("tc_c6", 1'b0, 1'b0, 5'b01000);
        step("tc_c7", 1'b0, 1'b0, 5'b01000);
        step("tc_c8", 1'b0, 1'b0, 5'b00000);

        step("bh_c2", 1'b1, 1'b0, 5'b11100);
        step("bh_c3", 1'b0, 1'b1, 5'b11000);
        step("bh_c4", 1'b1, 1'b1, 5'b11001);
        step("bh_c5", 1'b0, 1'b0, 5'b01010);
        step("bh_c6", 1'b0, 1'b0, 5'b01000);
        step("bh_c7", 1'b0, 1'b0, 5'b01000);
        step("bh_c8", 1'b0, 1'b0, 5'b00000);

        step("rst_c2", 1'b1, 1'b0, 5'b11100);
        step("rst_c3", 1'b0, 1'b1, 5'b11000);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", obs, 5'b00000);
        @(posedge clk);
        #1;
        check("rst_held", obs, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_c1", 1'b0, 1'b0, 5'b00000);
        step("post_rst_c2", 1'b0, 1'b0, 5'b00000);
        step("post_rst_c3", 1'b0, 1'b0, 5'b00000);
        step("post_rst_c4", 1'b0, 1'b0, 5'b00000);
        step("post_rst_rise", 1'b1, 1'b0, 5'b11100);
        step("post_rst_hold", 1'b0, 1'b0, 5'b11000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/output_conditioner.md
OUTPUT_CONDITIONER -- requirements
Module: output_conditioner

Interface
REQ-001 SHALL have parameter COUNTERWIDTH, default 3, hold-counter width in bits.
REQ-002 SHALL have parameter WAITTIME, default 3, minimum dwell between output transitions in clk cycles; legal range 1..2^COUNTERWIDTH-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rise_req  input  1  one-cycle pulse requesting drive go high.
REQ-006 SHALL have port fall_req  input  1  one-cycle pulse requesting drive go low.
REQ-007 SHALL have port drive  output  1  registered, glitch-free conditioned output level.
REQ-008 SHALL have port busy  output  1  high while a dwell hold is in progress.
REQ-009 SHALL have port risedone  output  1  one-cycle pulse in the first cycle drive is 1 after a 0->1 transition.
REQ-010 SHALL have port falldone  output  1  one-cycle pulse in the first cycle drive is 0 after a 1->0 transition.
REQ-011 SHALL have port dropped  output  1  one-cycle pulse when a request is discarded or overwritten.

Function
REQ-012 SHALL implement FSM states IDLE_LOW, HOLD_HIGH, IDLE_HIGH, HOLD_LOW; drive=1 in HOLD_HIGH/IDLE_HIGH, else 0.
REQ-013 SHALL, in IDLE_LOW on rise_req, enter HOLD_HIGH at the same edge; drive visible high after that edge (1-cycle latency), risedone high for that one cycle.
REQ-014 SHALL, in IDLE_HIGH on fall_req, enter HOLD_LOW symmetrically, with falldone pulse.
REQ-015 SHALL treat a request matching the current idle level as a no-op: no transition, no done pulse, no dropped pulse.
REQ-016 SHALL clear the hold counter to 0 on entry to a HOLD state and increment it by 1 each cycle thereafter; no wrap beyond WAITTIME-1.
REQ-017 SHALL leave a HOLD state at the edge where counter==WAITTIME-1: to the matching IDLE state, or directly to the opposite HOLD state if an opposite-level request is pending, so consecutive transitions are spaced exactly WAITTIME cycles.
REQ-018 SHALL store at most one pending request (target level plus valid bit) while in a HOLD state.
REQ-019 SHALL, on a new request while pending is valid, overwrite pending with the newer request and pulse dropped.
REQ-020 SHALL discard, at hold end, a pending request equal to the current level, clear pending, and pulse dropped.
REQ-021 SHALL treat rise_req and fall_req asserted in the same cycle as no request in any state and pulse dropped; existing pending unchanged.
REQ-022 SHALL sample a request arriving in the exact cycle counter==WAITTIME-1 as if pending, acting on it at that same edge.
REQ-023 SHALL assert busy exactly when the state is HOLD_HIGH or HOLD_LOW.
REQ-024 SHALL register all outputs; no combinational path from rise_req/fall_req to any output.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state IDLE_LOW, counter 0, pending invalid, drive 0, busy 0, risedone 0, falldone 0, dropped 0.
REQ-026 SHALL abandon any hold or pending request on reset mid-operation; first request after rst_n rises is handled as from IDLE_LOW.
REQ-027 SHALL ignore requests in the cycle rst_n deasserts only if rst_n is still 0 at that rising edge.

Structure
REQ-028 SHALL place the state encoding (2-bit, four named constants) in a shared package conditioner_pkg, alongside defaults for COUNTERWIDTH and WAITTIME.
REQ-029 SHALL implement the dwell counter as sub-module dwell_counter (clear, enable, terminal-count output), parameterised by COUNTERWIDTH and WAITTIME.

Verification (WAITTIME=3)
REQ-030 SHALL cover: reset, rise_req at cycle 1 -> drive=1 and risedone=1 from cycle 2, busy=1 cycles 2-4, busy=0 cycle 5.
REQ-031 SHALL cover: rise_req cycle 1, fall_req cycle 2 -> drive falls exactly at cycle 5, falldone at cycle 5, dropped never.
REQ-032 SHALL cover: rise_req cycle 1, fall_req cycle 2, rise_req cycle 3 -> dropped at cycle 4 (overwrite), then dropped at cycle 5 (same-level discard), drive stays 1.
REQ-033 SHALL cover: rise_req and fall_req together in IDLE_LOW -> dropped one cycle, drive stays 0, busy stays 0.
REQ-034 SHALL cover: rst_n low mid HOLD_HIGH with pending fall -> drive 0, busy 0 immediately (asynchronous), no falldone.
REQ-035 SHALL cover: fall_req in IDLE_LOW -> no output change, no pulses.
